// File: rtl/token_rx_sb_pkg.sv
// Shared types and constants for the token receive scoreboard.
package token_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    ACKW  = 2'd2
  } state_t;

  localparam logic BR_A = 1'b0;
  localparam logic BR_B = 1'b1;

  localparam int SYNC_STAGES_DEF = 2;

  // Lone request wins; on a tie the branch not served last time wins.
  function automatic logic pick_branch(input logic sa, input logic sb, input logic last_br);
    logic br;
    if (sa && sb) begin
      br = ~last_br;
    end else if (sb) begin
      br = BR_B;
    end else begin
      br = BR_A;
    end
    return br;
  endfunction

endpackage

// File: rtl/token_rx_sb_if.sv
// Handshake, token and status bundle between the branch stage/consumer and the receiver.
interface token_rx_sb_if #(
  parameter int CNT_W = 16
);
  logic             senda;
  logic             sendb;
  logic             acka;
  logic             ackb;
  logic             tok_valid;
  logic             tok_br;
  logic             tok_ready;
  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] cnt_b;
  logic             proto_err;

  modport master (
    output senda, sendb, tok_ready,
    input  acka, ackb, tok_valid, tok_br, cnt_a, cnt_b, proto_err
  );

  modport slave (
    input  senda, sendb, tok_ready,
    output acka, ackb, tok_valid, tok_br, cnt_a, cnt_b, proto_err
  );
endinterface

// File: rtl/token_rx_sb_sync.sv
// Bit synchronizer of configurable depth with asynchronous clear.
module token_rx_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff_r;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ff_r <= {STAGES{1'b0}};
    end else begin
      ff_r <= {ff_r[STAGES-2:0], d};
    end
  end

  assign q = ff_r[STAGES-1];

endmodule

// File: rtl/token_rx_sb.sv
// Merges two 4-phase branch requests into a clocked valid/ready token stream,
// acknowledging each branch and counting accepted tokens per branch.
module token_rx_sb
  import token_rx_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int CNT_W       = 16
) (
  input  logic         clk,
  input  logic         reset,
  token_rx_sb_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             sa_s, sb_s, s_sel_s;
  state_t           state_r, state_nx_s;
  logic             sel_r, sel_nx_s;
  logic             last_br_r, last_br_nx_s;
  logic             acka_r, acka_nx_s;
  logic             ackb_r, ackb_nx_s;
  logic             tok_valid_r, tok_valid_nx_s;
  logic             tok_br_r, tok_br_nx_s;
  logic [CNT_W-1:0] cnt_a_r, cnt_a_nx_s;
  logic [CNT_W-1:0] cnt_b_r, cnt_b_nx_s;
  logic             proto_err_r, proto_err_nx_s;

  token_rx_sync #(.STAGES(SYNC_STAGES)) u_sync_a (
    .clk   (clk),
    .reset (reset),
    .d     (bus.senda),
    .q     (sa_s)
  );

  token_rx_sync #(.STAGES(SYNC_STAGES)) u_sync_b (
    .clk   (clk),
    .reset (reset),
    .d     (bus.sendb),
    .q     (sb_s)
  );

  // Synchronized request of the branch currently being served.
  always_comb begin
    s_sel_s = sa_s;
    if (sel_r == BR_B) begin
      s_sel_s = sb_s;
    end else begin
      s_sel_s = sa_s;
    end
  end

  // Next-state and next-output logic of the handshake FSM.
  always_comb begin
    state_nx_s     = state_r;
    sel_nx_s       = sel_r;
    last_br_nx_s   = last_br_r;
    acka_nx_s      = acka_r;
    ackb_nx_s      = ackb_r;
    tok_valid_nx_s = tok_valid_r;
    tok_br_nx_s    = tok_br_r;
    cnt_a_nx_s     = cnt_a_r;
    cnt_b_nx_s     = cnt_b_r;
    proto_err_nx_s = proto_err_r;
    case (state_r)
      IDLE: begin
        if (sa_s || sb_s) begin
          sel_nx_s       = pick_branch(sa_s, sb_s, last_br_r);
          tok_br_nx_s    = pick_branch(sa_s, sb_s, last_br_r);
          tok_valid_nx_s = 1'b1;
          state_nx_s     = OFFER;
        end else begin
          state_nx_s = IDLE;
        end
      end
      OFFER: begin
        // A withdrawn request is a violation even if the consumer is ready.
        if (!s_sel_s) begin
          proto_err_nx_s = 1'b1;
          tok_valid_nx_s = 1'b0;
          state_nx_s     = IDLE;
        end else if (bus.tok_ready) begin
          tok_valid_nx_s = 1'b0;
          last_br_nx_s   = sel_r;
          state_nx_s     = ACKW;
          if (sel_r == BR_B) begin
            ackb_nx_s  = 1'b1;
            cnt_b_nx_s = cnt_b_r + CNT_ONE;
          end else begin
            acka_nx_s  = 1'b1;
            cnt_a_nx_s = cnt_a_r + CNT_ONE;
          end
        end else begin
          state_nx_s = OFFER;
        end
      end
      ACKW: begin
        if (!s_sel_s) begin
          acka_nx_s  = 1'b0;
          ackb_nx_s  = 1'b0;
          state_nx_s = IDLE;
        end else begin
          state_nx_s = ACKW;
        end
      end
      default: begin
        acka_nx_s      = 1'b0;
        ackb_nx_s      = 1'b0;
        tok_valid_nx_s = 1'b0;
        state_nx_s     = IDLE;
      end
    endcase
  end

  // State and registered outputs; LAST_BR resets to B so A wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      sel_r       <= BR_A;
      last_br_r   <= BR_B;
      acka_r      <= 1'b0;
      ackb_r      <= 1'b0;
      tok_valid_r <= 1'b0;
      tok_br_r    <= 1'b0;
      cnt_a_r     <= {CNT_W{1'b0}};
      cnt_b_r     <= {CNT_W{1'b0}};
      proto_err_r <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      sel_r       <= sel_nx_s;
      last_br_r   <= last_br_nx_s;
      acka_r      <= acka_nx_s;
      ackb_r      <= ackb_nx_s;
      tok_valid_r <= tok_valid_nx_s;
      tok_br_r    <= tok_br_nx_s;
      cnt_a_r     <= cnt_a_nx_s;
      cnt_b_r     <= cnt_b_nx_s;
      proto_err_r <= proto_err_nx_s;
    end
  end

  assign bus.acka      = acka_r;
  assign bus.ackb      = ackb_r;
  assign bus.tok_valid = tok_valid_r;
  assign bus.tok_br    = tok_br_r;
  assign bus.cnt_a     = cnt_a_r;
  assign bus.cnt_b     = cnt_b_r;
  assign bus.proto_err = proto_err_r;

endmodule

// File: tb/tb_token_rx_sb.sv
// Directed self-checking bench for token_rx_sb (SYNC_STAGES=2, CNT_W=4).
module tb_token_rx_sb;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  token_rx_sb_if #(.CNT_W(4)) bus ();

  token_rx_sb #(.SYNC_STAGES(2), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.senda = 1'b0;
    bus.sendb = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // One full token on branch br with the consumer always ready, from IDLE.
  task automatic do_token(input logic br);
    int k;
    bus.tok_ready = 1'b1;
    if (br) bus.sendb = 1'b1; else bus.senda = 1'b1;
    tick();
    tick();
    check("tok_lat_lo", bus.tok_valid, 0);
    tick();
    check("tok_valid", bus.tok_valid, 1);
    check("tok_br", bus.tok_br, br);
    tick();
    check("ack_sel", br ? bus.ackb : bus.acka, 1);
    check("ack_other", br ? bus.acka : bus.ackb, 0);
    if (br) bus.sendb = 1'b0; else bus.senda = 1'b0;
    k = 0;
    while ((br ? bus.ackb : bus.acka) && k < 10) begin
      tick();
      k++;
    end
    check("ack_fall", br ? bus.ackb : bus.acka, 0);
  endtask

  initial begin
    int k;
    bus.senda     = 1'b0;
    bus.sendb     = 1'b0;
    bus.tok_ready = 1'b0;

    // Reset state
    do_reset();
    check("rst_acka", bus.acka, 0);
    check("rst_ackb", bus.ackb, 0);
    check("rst_valid", bus.tok_valid, 0);
    check("rst_br", bus.tok_br, 0);
    check("rst_cnt_a", bus.cnt_a, 0);
    check("rst_cnt_b", bus.cnt_b, 0);
    check("rst_perr", bus.proto_err, 0);

    // Single A token, latency and ack release
    bus.tok_ready = 1'b1;
    bus.senda = 1'b1;
    tick();
    check("a_e1_valid", bus.tok_valid, 0);
    tick();
    check("a_e2_valid", bus.tok_valid, 0);
    tick();
    check("a_e3_valid", bus.tok_valid, 1);
    check("a_e3_br", bus.tok_br, 0);
    tick();
    check("a_e4_acka", bus.acka, 1);
    check("a_e4_valid", bus.tok_valid, 0);
    check("a_e4_cnt", bus.cnt_a, 1);
    bus.senda = 1'b0;
    tick();
    check("a_hold1", bus.acka, 1);
    tick();
    check("a_hold2", bus.acka, 1);
    tick();
    check("a_drop", bus.acka, 0);

    // Simultaneous requests after reset: A first, then B
    do_reset();
    bus.tok_ready = 1'b1;
    bus.senda = 1'b1;
    bus.sendb = 1'b1;
    tick();
    tick();
    tick();
    check("tie_valid", bus.tok_valid, 1);
    check("tie_br_a", bus.tok_br, 0);
    tick();
    check("tie_acka", bus.acka, 1);
    check("tie_ackb", bus.ackb, 0);
    bus.senda = 1'b0;
    k = 0;
    while (!bus.ackb && k < 20) begin
      tick();
      check("no_overlap", bus.acka & bus.ackb, 0);
      k++;
    end
    check("tie_ackb_up", bus.ackb, 1);
    check("tie_br_b", bus.tok_br, 1);
    check("tie_cnt_a", bus.cnt_a, 1);
    check("tie_cnt_b", bus.cnt_b, 1);
    bus.sendb = 1'b0;
    k = 0;
    while (bus.ackb && k < 10) begin
      tick();
      check("no_overlap2", bus.acka & bus.ackb, 0);
      k++;
    end
    check("tie_ackb_fall", bus.ackb, 0);

    // Back-pressure on a B token
    do_reset();
    bus.tok_ready = 1'b0;
    bus.sendb = 1'b1;
    tick();
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", bus.tok_valid, 1);
      check("bp_br", bus.tok_br, 1);
      check("bp_ackb", bus.ackb, 0);
      tick();
    end
    bus.tok_ready = 1'b1;
    tick();
    check("bp_ackb_up", bus.ackb, 1);
    check("bp_valid_lo", bus.tok_valid, 0);
    check("bp_cnt_b", bus.cnt_b, 1);
    bus.sendb = 1'b0;
    k = 0;
    while (bus.ackb && k < 10) begin
      tick();
      k++;
    end
    check("bp_ackb_fall", bus.ackb, 0);

    // Request withdrawn while offered
    do_reset();
    bus.tok_ready = 1'b0;
    bus.senda = 1'b1;
    tick();
    tick();
    tick();
    check("pe_valid", bus.tok_valid, 1);
    bus.senda = 1'b0;
    tick();
    check("pe_valid1", bus.tok_valid, 1);
    tick();
    check("pe_valid2", bus.tok_valid, 1);
    tick();
    check("pe_set", bus.proto_err, 1);
    check("pe_valid_lo", bus.tok_valid, 0);
    check("pe_acka", bus.acka, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("pe_sticky", bus.proto_err, 1);
      check("pe_noack", bus.acka, 0);
      check("pe_cnt_a", bus.cnt_a, 0);
    end
    do_token(1'b0);
    check("pe_after_cnt", bus.cnt_a, 1);
    check("pe_after_flag", bus.proto_err, 1);

    // Counter wrap at CNT_W=4
    do_reset();
    for (int i = 0; i < 15; i++) begin
      do_token(1'b0);
    end
    check("wrap_pre", bus.cnt_a, 15);
    do_token(1'b0);
    check("wrap_zero", bus.cnt_a, 0);
    check("wrap_cnt_b", bus.cnt_b, 0);

    // Asynchronous reset in the middle of the ack phase
    do_reset();
    bus.tok_ready = 1'b1;
    bus.senda = 1'b1;
    tick();
    tick();
    tick();
    tick();
    check("ar_acka", bus.acka, 1);
    check("ar_cnt", bus.cnt_a, 1);
    #2;
    reset = 1'b1;
    #1;
    check("ar_acka_lo", bus.acka, 0);
    check("ar_valid", bus.tok_valid, 0);
    check("ar_cnt_a", bus.cnt_a, 0);
    check("ar_perr", bus.proto_err, 0);
    bus.senda = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    do_token(1'b0);
    check("ar_resume_cnt", bus.cnt_a, 1);
    do_token(1'b1);
    check("ar_resume_cnt_b", bus.cnt_b, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
